arm_multicycle_ctrl: RTL and testbench
======================================

Name: arm_multicycle_ctrl

Overview:
Parametrised multicycle control unit for the ARM core: a Moore FSM sequencing fetch, decode, execute, memory and writeback. It owns the instruction register, evaluates ARM condition codes against the NZCV flags, and handshakes with the memory interface with a configurable timeout. It also counts retired instructions. It sits between the memory interface and the datapath (register file, ALU, PC), driving all datapath enables.

Parameters:
INSTR_W, 32, instruction/IR width; fields below assume 32.
MEM_TIMEOUT, 16, max wait cycles per memory access before FAULT; 0 disables timeout.
ENABLE_COND, 1, 1 = evaluate cond field; 0 = treat every cond except 4'b1111 as AL.
RETIRE_W, 32, width of retired-instruction counter.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset.
mem_rdata  in  INSTR_W  instruction word from memory.
mem_ready  in  1  memory completes current access this cycle.
flags_nzcv  in  4  current N,Z,C,V from the flags register.
ir  out  INSTR_W  instruction register.
mem_req  out  1  memory access request.
mem_we  out  1  1 = store.
mem_addr_sel  out  1  0 = PC, 1 = ALU result.
pc_we  out  1  PC write enable.
pc_sel  out  1  0 = PC+4, 1 = branch target.
alu_en  out  1  ALU operation valid.
flags_we  out  1  flags register write.
rf_we  out  1  register file write.
rf_wsel  out  2  0 = ALU, 1 = mem data, 2 = link (PC).
retired  out  1  one-cycle pulse per retired instruction.
undef  out  1  one-cycle pulse on undefined instruction.
fault  out  1  level; memory timeout occurred.
retire_count  out  RETIRE_W  retired instruction count.
state  out  3  current state encoding.

Behaviour:
- Reset asserted: state=IDLE, ir=0, retire_count=0, timeout counter=0, every output 0. Asynchronous; it aborts any access mid-flight.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, FAULT.
- IDLE -> FETCH unconditionally on the next clk.
- FETCH:
  - mem_req=1, mem_addr_sel=0, mem_we=0.
  - On mem_ready=1: ir<=mem_rdata, go to DECODE; else stay.
- DECODE:
  - pc_we=1, pc_sel=0 (PC+4, always).
  - ir[31:28]==4'b1111 -> undef=1, go to FETCH.
  - cond fails -> retired=1, go to FETCH.
  - Class by ir[27:25]: 00x data-proc; 01x load/store; 101 branch; others -> undef=1, go to FETCH.
  - Valid class with cond passed -> EXEC.
- EXEC:
  - alu_en=1.
  - Data-proc: flags_we=ir[20]. If opcode ir[24:21] is 1000-1011 (TST/TEQ/CMP/CMN): retired=1, go to FETCH; else go to WB.
  - Load/store: go to MEM.
  - Branch: pc_we=1, pc_sel=1. If ir[24]=1 (BL) go to WB; else retired=1, go to FETCH.
- MEM:
  - mem_req=1, mem_addr_sel=1, mem_we=~ir[20].
  - On mem_ready=1: store -> retired=1, go to FETCH; load -> go to WB.
- WB:
  - rf_we=1; rf_wsel=0 for data-proc, 1 for load, 2 for BL.
  - retired=1, go to FETCH.
- FAULT: fault=1, all other outputs 0; absorbing until reset.
- Handshake: mem_req and address/we selects stay stable from assertion until the cycle mem_ready=1 is sampled. mem_ready with mem_req=0 is ignored.
- Timeout:
  - Counter clears on entry to FETCH/MEM.
  - It increments each cycle in FETCH/MEM with mem_ready=0.
  - When it equals MEM_TIMEOUT and mem_ready=0, go to FAULT next cycle.
  - mem_ready=1 in that same cycle wins: the access completes.
- Cond evaluation: EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL 1. Uses flags_nzcv sampled in DECODE.
- retire_count increments on each retired pulse, wrapping modulo 2^RETIRE_W. Cond-failed instructions count as retired; undefined instructions do not.
- Cycle counts with zero wait states:
  - cond-fail/undef: 2.
  - B: 3.
  - data-proc writeback, BL, store: 4.
  - compare: 3.
  - load: 5.
  - Each wait cycle adds 1.

Decomposition:
- Package arm_ctrl_pkg: state encodings; cond code constants (EQ..AL, NV); instruction class codes; rf_wsel encodings; opcode range for compare ops.
- Sub-module arm_cond_eval: combinational, inputs cond[3:0] and nzcv[3:0], output pass.

Test Plan:
- Reset mid-MEM (load, mem_ready=0), reset=0 -> all outputs 0 and state=IDLE immediately; after release, FETCH on the 2nd clk.
- ADD r1 (0xE0811002), mem_ready always 1 -> FETCH, DECODE, EXEC, WB over 4 cycles; rf_we=1 with rf_wsel=0 in WB; retire_count=1.
- BEQ (0x0A000004), flags_nzcv=4'b0000 -> returns to FETCH after DECODE; retired=1; pc_we only in DECODE with pc_sel=0. Same with Z=1 -> EXEC pc_we=1, pc_sel=1.
- LDR (0xE5912000), mem_ready low 3 cycles in MEM -> mem_req/mem_addr_sel=1 held 4 cycles; WB rf_wsel=1; total 8 cycles.
- MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH -> FAULT after 5 FETCH cycles; fault=1 until reset.
- ir=0xF0000000, then 0xE6000010 -> undef pulse for each, retire_count unchanged; undef deasserts the next cycle.

Source files
------------

// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the ARM multicycle control unit: FSM states, condition
// codes, instruction classes, register-file write selects and per-state controls.
package arm_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_FAULT  = 3'd6
  } state_e;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  typedef enum logic [1:0] {
    CLS_DP    = 2'd0,
    CLS_LS    = 2'd1,
    CLS_BR    = 2'd2,
    CLS_UNDEF = 2'd3
  } cls_e;

  localparam logic [1:0] WSEL_ALU  = 2'd0;
  localparam logic [1:0] WSEL_MEM  = 2'd1;
  localparam logic [1:0] WSEL_LINK = 2'd2;

  // TST/TEQ/CMP/CMN only update flags and never write a register.
  localparam logic [3:0] OP_CMP_LO = 4'b1000;
  localparam logic [3:0] OP_CMP_HI = 4'b1011;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       pc_we;
    logic       pc_sel;
    logic       alu_en;
    logic       flags_we;
    logic       rf_we;
    logic [1:0] rf_wsel;
  } ctrl_t;

  // Register-offset encodings with bit 4 set in the 011 space are architecturally undefined.
  function automatic cls_e instr_class(input logic [2:0] op, input logic bit4);
    cls_e cls;
    cls = CLS_UNDEF;
    if (op[2:1] == 2'b00) begin
      cls = CLS_DP;
    end else if (op == 3'b010 || (op == 3'b011 && !bit4)) begin
      cls = CLS_LS;
    end else if (op == 3'b101) begin
      cls = CLS_BR;
    end
    return cls;
  endfunction

  function automatic ctrl_t state_ctrl(input state_e st, input cls_e cls, input logic l_bit);
    ctrl_t c;
    c = '0;
    case (st)
      ST_FETCH: begin
        c.mem_req = 1'b1;
      end
      ST_DECODE: begin
        c.pc_we = 1'b1;
      end
      ST_EXEC: begin
        c.alu_en = 1'b1;
        if (cls == CLS_DP) begin
          c.flags_we = l_bit;
        end
        if (cls == CLS_BR) begin
          c.pc_we  = 1'b1;
          c.pc_sel = 1'b1;
        end
      end
      ST_MEM: begin
        c.mem_req      = 1'b1;
        c.mem_addr_sel = 1'b1;
        c.mem_we       = ~l_bit;
      end
      ST_WB: begin
        c.rf_we = 1'b1;
        case (cls)
          CLS_LS:  c.rf_wsel = WSEL_MEM;
          CLS_BR:  c.rf_wsel = WSEL_LINK;
          default: c.rf_wsel = WSEL_ALU;
        endcase
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/arm_multicycle_ctrl_cond_eval.sv
// ARM condition-code evaluator: decides whether an instruction executes given NZCV.
module arm_cond_eval
  import arm_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;
  assign {n, z, c, v} = nzcv;

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/arm_multicycle_ctrl.sv
// Multicycle ARM control FSM: fetch/decode/execute/memory/writeback sequencing,
// instruction register, memory timeout and retired-instruction counter.
module arm_multicycle_ctrl
  import arm_ctrl_pkg::*;
#(
  parameter int INSTR_W     = 32,
  parameter int MEM_TIMEOUT = 16,
  parameter int ENABLE_COND = 1,
  parameter int RETIRE_W    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [INSTR_W-1:0]  mem_rdata,
  input  logic                mem_ready,
  input  logic [3:0]          flags_nzcv,
  output logic [INSTR_W-1:0]  ir,
  output logic                mem_req,
  output logic                mem_we,
  output logic                mem_addr_sel,
  output logic                pc_we,
  output logic                pc_sel,
  output logic                alu_en,
  output logic                flags_we,
  output logic                rf_we,
  output logic [1:0]          rf_wsel,
  output logic                retired,
  output logic                undef,
  output logic                fault,
  output logic [RETIRE_W-1:0] retire_count,
  output logic [2:0]          state
);

  localparam int TMO_W = $clog2(MEM_TIMEOUT + 2);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(MEM_TIMEOUT);
  localparam bit TMO_ON = (MEM_TIMEOUT != 0);

  state_e                state_q, state_d;
  logic [INSTR_W-1:0]    ir_q, ir_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  ctrl_t                 ctrl_q, ctrl_d;
  logic                  retired_q, retired_d;
  logic                  undef_q, undef_d;
  logic                  fault_q, fault_d;
  logic [RETIRE_W-1:0]   retire_count_q, retire_count_d;

  logic cond_pass, cond_ok, is_cmp;
  cls_e cls;

  arm_cond_eval u_cond (
    .cond (ir_q[31:28]),
    .nzcv (flags_nzcv),
    .pass (cond_pass)
  );

  assign cond_ok = (ENABLE_COND != 0) ? cond_pass : 1'b1;
  assign cls     = instr_class(ir_q[27:25], ir_q[4]);
  assign is_cmp  = (ir_q[24:21] >= OP_CMP_LO) && (ir_q[24:21] <= OP_CMP_HI);

  // Memory handshake: mem_req is a registered level raised on entry to FETCH/MEM
  // and held, with mem_we/mem_addr_sel, until a cycle where mem_ready=1 is sampled;
  // mem_ready seen while mem_req=0 has no effect.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    tmo_d     = tmo_q;
    retired_d = 1'b0;
    undef_d   = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH, ST_MEM: begin
        if (mem_ready) begin
          if (state_q == ST_FETCH) begin
            ir_d    = mem_rdata;
            state_d = ST_DECODE;
          end else if (ir_q[20]) begin
            state_d = ST_WB;
          end else begin
            retired_d = 1'b1;
            state_d   = ST_FETCH;
          end
        end else if (TMO_ON && tmo_q == TMO_LIMIT) begin
          state_d = ST_FAULT;
        end else if (TMO_ON) begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_DECODE: begin
        if (ir_q[31:28] == COND_NV) begin
          undef_d = 1'b1;
          state_d = ST_FETCH;
        end else if (!cond_ok) begin
          retired_d = 1'b1;
          state_d   = ST_FETCH;
        end else if (cls == CLS_UNDEF) begin
          undef_d = 1'b1;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (cls)
          CLS_DP: begin
            if (is_cmp) begin
              retired_d = 1'b1;
              state_d   = ST_FETCH;
            end else begin
              state_d = ST_WB;
            end
          end
          CLS_LS: state_d = ST_MEM;
          CLS_BR: begin
            if (ir_q[24]) begin
              state_d = ST_WB;
            end else begin
              retired_d = 1'b1;
              state_d   = ST_FETCH;
            end
          end
          default: state_d = ST_FETCH;
        endcase
      end
      ST_WB: begin
        retired_d = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_IDLE;
    endcase

    if ((state_d == ST_FETCH || state_d == ST_MEM) && state_d != state_q) begin
      tmo_d = '0;
    end

    // Outputs are registered from the next state so they line up with it;
    // retired/undef therefore pulse in the cycle after the deciding state.
    ctrl_d         = state_ctrl(state_d, instr_class(ir_d[27:25], ir_d[4]), ir_d[20]);
    fault_d        = (state_d == ST_FAULT);
    retire_count_d = retire_count_q + {{(RETIRE_W-1){1'b0}}, retired_d};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      ir_q           <= '0;
      tmo_q          <= '0;
      ctrl_q         <= '0;
      retired_q      <= 1'b0;
      undef_q        <= 1'b0;
      fault_q        <= 1'b0;
      retire_count_q <= '0;
    end else begin
      state_q        <= state_d;
      ir_q           <= ir_d;
      tmo_q          <= tmo_d;
      ctrl_q         <= ctrl_d;
      retired_q      <= retired_d;
      undef_q        <= undef_d;
      fault_q        <= fault_d;
      retire_count_q <= retire_count_d;
    end
  end

  assign ir           = ir_q;
  assign mem_req      = ctrl_q.mem_req;
  assign mem_we       = ctrl_q.mem_we;
  assign mem_addr_sel = ctrl_q.mem_addr_sel;
  assign pc_we        = ctrl_q.pc_we;
  assign pc_sel       = ctrl_q.pc_sel;
  assign alu_en       = ctrl_q.alu_en;
  assign flags_we     = ctrl_q.flags_we;
  assign rf_we        = ctrl_q.rf_we;
  assign rf_wsel      = ctrl_q.rf_wsel;
  assign retired      = retired_q;
  assign undef        = undef_q;
  assign fault        = fault_q;
  assign retire_count = retire_count_q;
  assign state        = state_q;

endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// Directed bench for arm_multicycle_ctrl: an instruction-level model expands each
// instruction into its expected per-cycle phase trace; a compare process checks every cycle.
module tb_arm_multicycle_ctrl;
  import arm_ctrl_pkg::*;

  localparam int TMO = 4;
  localparam int K_DP = 0, K_LS = 1, K_BR = 2, K_UND = 3;
  localparam int E_NONE = 0, E_RET = 1, E_UND = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic [3:0]  flags_nzcv = '0;
  logic [31:0] ir;
  logic        mem_req, mem_we, mem_addr_sel, pc_we, pc_sel, alu_en, flags_we, rf_we;
  logic [1:0]  rf_wsel;
  logic        retired, undef, fault;
  logic [31:0] retire_count;
  logic [2:0]  state;

  arm_multicycle_ctrl #(
    .INSTR_W(32), .MEM_TIMEOUT(TMO), .ENABLE_COND(1), .RETIRE_W(32)
  ) dut (
    .clk(clk), .reset(reset), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .flags_nzcv(flags_nzcv), .ir(ir), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .pc_we(pc_we), .pc_sel(pc_sel), .alu_en(alu_en),
    .flags_we(flags_we), .rf_we(rf_we), .rf_wsel(rf_wsel), .retired(retired),
    .undef(undef), .fault(fault), .retire_count(retire_count), .state(state)
  );

  // clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int total = 0;
  int bad   = 0;

  logic [23:0] exp_q[$];
  logic [2:0]  ph_q[$];
  bit          rdy_q[$];
  int          endk;
  bit          faulted;
  bit          pend_ret, pend_und;
  logic [7:0]  exp_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---- model ----
  function automatic int kind(input logic [31:0] i);
    if (i[27:26] == 2'b00) return K_DP;
    if (i[27:25] == 3'b010 || (i[27:25] == 3'b011 && !i[4])) return K_LS;
    if (i[27:25] == 3'b101) return K_BR;
    return K_UND;
  endfunction

  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  function automatic logic [23:0] exp_vec(input logic [2:0] st, input logic [31:0] instr,
                                          input bit ret, input bit und, input logic [7:0] cnt);
    logic mreq, mwe, masel, pcwe, pcsel, alu, fwe, rfwe, flt;
    logic [1:0] wsel;
    int k;
    {mreq, mwe, masel, pcwe, pcsel, alu, fwe, rfwe, flt} = '0;
    wsel = 2'd0;
    k = kind(instr);
    case (st)
      ST_FETCH:  mreq = 1'b1;
      ST_DECODE: pcwe = 1'b1;
      ST_EXEC: begin
        alu = 1'b1;
        if (k == K_DP) fwe = instr[20];
        if (k == K_BR) begin pcwe = 1'b1; pcsel = 1'b1; end
      end
      ST_MEM: begin mreq = 1'b1; masel = 1'b1; mwe = !instr[20]; end
      ST_WB: begin
        rfwe = 1'b1;
        wsel = (k == K_LS) ? 2'd1 : (k == K_BR) ? 2'd2 : 2'd0;
      end
      ST_FAULT: flt = 1'b1;
      default: ;
    endcase
    return {st, mreq, mwe, masel, pcwe, pcsel, alu, fwe, rfwe, wsel, ret, und, flt, cnt};
  endfunction

  task automatic add_phase(input logic [2:0] st, input bit rdy);
    ph_q.push_back(st);
    rdy_q.push_back(rdy);
  endtask

  task automatic add_access(input logic [2:0] st, input int waits);
    if (waits > TMO) begin
      for (int i = 0; i <= TMO; i++) add_phase(st, 1'b0);
      faulted = 1'b1;
    end else begin
      for (int i = 0; i < waits; i++) add_phase(st, 1'b0);
      add_phase(st, 1'b1);
    end
  endtask

  // Expand one instruction into its expected phase trace, then drive and score it.
  task automatic run_instr(input logic [31:0] instr, input logic [3:0] nzcv, input int fw,
                           input int mw, input int stop_at, output int ncyc);
    int k;
    bit last;
    ph_q.delete(); rdy_q.delete();
    faulted = 1'b0; endk = E_NONE;
    k = kind(instr);
    add_access(ST_FETCH, fw);
    if (!faulted) begin
      add_phase(ST_DECODE, 1'b1);
      if (instr[31:28] == 4'hF) endk = E_UND;
      else if (!cond_ok(instr[31:28], nzcv)) endk = E_RET;
      else if (k == K_UND) endk = E_UND;
      else begin
        add_phase(ST_EXEC, 1'b1);
        endk = E_RET;
        if (k == K_DP && !(instr[24:21] >= 4'd8 && instr[24:21] <= 4'd11)) add_phase(ST_WB, 1'b1);
        if (k == K_BR && instr[24]) add_phase(ST_WB, 1'b1);
        if (k == K_LS) begin
          add_access(ST_MEM, mw);
          if (faulted) endk = E_NONE;
          else if (instr[20]) add_phase(ST_WB, 1'b1);
        end
      end
    end
    ncyc = ph_q.size();
    if (faulted) for (int i = 0; i < 4; i++) add_phase(ST_FAULT, 1'($urandom_range(0, 1)));
    for (int i = 0; i < ph_q.size(); i++) begin
      if (stop_at >= 0 && i == stop_at) break;
      mem_ready  = rdy_q[i];
      mem_rdata  = (ph_q[i] == ST_FETCH) ? instr : $urandom();
      flags_nzcv = nzcv;
      last = (i == ncyc - 1) && !faulted;
      exp_q.push_back(exp_vec(ph_q[i], instr, pend_ret, pend_und, exp_cnt));
      pend_ret = last && (endk == E_RET);
      pend_und = last && (endk == E_UND);
      if (pend_ret) exp_cnt++;
      @(posedge clk); #2;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_state", state, 0);
    chk("rst_ir", ir, 0);
    chk("rst_outs", {mem_req, mem_we, mem_addr_sel, pc_we, pc_sel, alu_en, flags_we,
                     rf_we, rf_wsel, retired, undef, fault}, 0);
    chk("rst_count", retire_count, 0);
    exp_q.delete();
    pend_ret = 1'b0; pend_und = 1'b0; exp_cnt = '0;
    repeat (2) @(posedge clk);
    #2;
    reset     = 1'b1;
    mem_ready = 1'b1;
    exp_q.push_back(exp_vec(ST_IDLE, 32'h0, 1'b0, 1'b0, 8'd0));
    @(posedge clk); #2;
  endtask

  // ---- scoreboard compare ----
  logic [23:0] cmp_e, cmp_a;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cmp_e = exp_q.pop_front();
      cmp_a = {state, mem_req, mem_we, mem_addr_sel, pc_we, pc_sel, alu_en, flags_we,
               rf_we, rf_wsel, retired, undef, fault, retire_count[7:0]};
      total++;
      if (cmp_a !== cmp_e) begin
        bad++;
        $display("FAIL cycle t=%0t actual=%h required=%h", $time, cmp_a, cmp_e);
      end
    end
  end

  // ---- driver ----
  logic [31:0] tbl [8];
  int n;

  initial begin
    tbl = '{32'hE0811002, 32'hE0911002, 32'hE1510002, 32'hE5912000,
            32'hE5812000, 32'hEA000003, 32'hEB000010, 32'h0A000004};
    #3;
    do_reset();

    run_instr(32'hE0811002, 4'b0000, 0, 0, -1, n);
    chk("cyc_add", n, 4);
    chk("cnt_add", retire_count, 1);
    chk("ir_add", ir, 32'hE0811002);

    run_instr(32'h0A000004, 4'b0000, 0, 0, -1, n);
    chk("cyc_beq_fail", n, 2);
    chk("cnt_beq_fail", retire_count, 2);

    run_instr(32'h0A000004, 4'b0100, 0, 0, -1, n);
    chk("cyc_beq_taken", n, 3);

    run_instr(32'hE5912000, 4'b0000, 0, 3, -1, n);
    chk("cyc_ldr_w3", n, 8);

    run_instr(32'hE5812000, 4'b0000, 0, 0, -1, n);
    chk("cyc_str", n, 4);

    run_instr(32'hE1510002, 4'b0000, 0, 0, -1, n);
    chk("cyc_cmp", n, 3);

    run_instr(32'hEB000010, 4'b0000, 0, 0, -1, n);
    chk("cyc_bl", n, 4);
    chk("cnt_bl", retire_count, 7);

    run_instr(32'hF0000000, 4'b0000, 0, 0, -1, n);
    chk("cyc_undef_nv", n, 2);
    chk("undef_pulse", undef, 1);
    run_instr(32'hE6000010, 4'b0000, 0, 0, -1, n);
    chk("cnt_after_undef", retire_count, 7);

    run_instr(32'hE0811002, 4'b0000, TMO, 0, -1, n);
    chk("cyc_fetch_wait_limit", n, 4 + TMO);

    for (int c = 0; c < 15; c++) begin
      for (int r = 0; r < 2; r++) begin
        run_instr({4'(c), 28'h0811002}, 4'($urandom_range(0, 15)), 0, 0, -1, n);
      end
    end

    for (int r = 0; r < 20; r++) begin
      run_instr(tbl[$urandom_range(0, 7)], 4'($urandom_range(0, 15)),
                $urandom_range(0, TMO), $urandom_range(0, TMO), -1, n);
    end

    run_instr(32'hE5912000, 4'b0000, 0, 10, 5, n);
    do_reset();
    run_instr(32'hE0811002, 4'b0000, 0, 0, -1, n);
    chk("cnt_after_reset", retire_count, 1);

    run_instr(32'hE0811002, 4'b0000, TMO + 1, 0, -1, n);
    chk("fault_level", fault, 1);
    do_reset();

    run_instr(32'hE5812000, 4'b0000, 0, TMO + 3, -1, n);
    chk("fault_mem_level", fault, 1);
    do_reset();

    @(negedge clk); #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
